ifmap_stream_loader: RTL and testbench

//  Upstream stage of cnn_accelerator. Accepts one ifmap frame as a raster-order pixel stream over valid/ready.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/raster_addr_gen.sv | 36 +++
 rtl/ifmap_stream_loader.sv | 126 ++++++++++++
 tb/tb_ifmap_stream_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types for the cnn_accelerator front-end: loader FSM states, pixel type, counter widths.
package cnn_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2,
    SKIP    = 2'd3
  } loader_state_e;

  localparam int unsigned PIXEL_W     = 8;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order row/col counter: increments col, wraps into row, flags the final pixel of the frame.
module raster_addr_gen #(
  parameter int unsigned HEIGHT = 128,
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  parameter int unsigned COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_pix_c
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign last_pix_c = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/ifmap_stream_loader.sv
// Streams one raster-order ifmap frame into an HxW buffer, then enables the accelerator until done.
// Optional framing check on s_last enabled by IFMAP_TLAST_CHECK_EN.
module ifmap_stream_loader
  import cnn_pkg::*;
#(
  parameter int unsigned IFMAP_HEIGHT = 128,
  parameter int unsigned IFMAP_WIDTH  = 128,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic [DATA_WIDTH-1:0]  ifmap_out [0:IFMAP_HEIGHT-1][0:IFMAP_WIDTH-1],
  output logic                   acc_en,
  input  logic                   acc_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   frame_err
);

  localparam int unsigned ROW_W = (IFMAP_HEIGHT > 1) ? $clog2(IFMAP_HEIGHT) : 1;
  localparam int unsigned COL_W = (IFMAP_WIDTH > 1) ? $clog2(IFMAP_WIDTH) : 1;

  loader_state_e state, next_state;

  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic                  last_pix_c;
  logic                  accept_c;
  logic                  load_beat_c;
  logic                  early_last_c;
  logic                  missing_last_c;
  logic                  skip_end_c;
  logic                  wr_en_c;
  logic                  inc_c;
  logic                  clear_c;
  logic                  s_ready_d;
  logic                  acc_en_d;
  logic                  frame_err_d;
  logic                  fire_c;
  logic [DATA_WIDTH-1:0] frame_buf [0:IFMAP_HEIGHT-1][0:IFMAP_WIDTH-1];

  assign accept_c    = s_valid && s_ready;
  assign load_beat_c = accept_c && (state == LOAD);

`ifdef IFMAP_TLAST_CHECK_EN
  assign early_last_c   = load_beat_c && s_last && !last_pix_c;
  assign missing_last_c = load_beat_c && !s_last && last_pix_c;
  assign skip_end_c     = accept_c && (state == SKIP) && s_last;
`else
  logic unused_last;
  assign unused_last    = s_last;
  assign early_last_c   = 1'b0;
  assign missing_last_c = 1'b0;
  assign skip_end_c     = 1'b0;
`endif

  raster_addr_gen #(
    .HEIGHT (IFMAP_HEIGHT),
    .WIDTH  (IFMAP_WIDTH),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_addr (
    .clk        (clk),
    .reset      (reset),
    .inc        (inc_c),
    .clear      (clear_c),
    .row        (row),
    .col        (col),
    .last_pix_c (last_pix_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= next_state;
  end

  // RELEASE waits for done to fall so a level-style done fires only once per frame
  always_comb begin
    next_state = state;
    case (state)
      LOAD: begin
        if (load_beat_c && !early_last_c && last_pix_c)
          next_state = missing_last_c ? SKIP : RUN;
      end
      RUN:     if (acc_done)   next_state = RELEASE;
      RELEASE: if (!acc_done)  next_state = LOAD;
      SKIP:    if (skip_end_c) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_comb begin
    wr_en_c     = load_beat_c;
    inc_c       = load_beat_c && !early_last_c;
    clear_c     = early_last_c;
    s_ready_d   = (next_state == LOAD) || (next_state == SKIP);
    acc_en_d    = (next_state == RUN);
    fire_c      = (state == LOAD) && (next_state == RUN);
    frame_err_d = early_last_c || missing_last_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready   <= 1'b0;
      acc_en    <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      s_ready   <= s_ready_d;
      acc_en    <= acc_en_d;
      frame_err <= frame_err_d;
      if (fire_c) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  // Frame buffer has no reset; acc_en low guards its contents until a frame completes
  always_ff @(posedge clk) begin
    if (wr_en_c && !reset) frame_buf[row][col] <= s_data;
  end

  assign ifmap_out = frame_buf;

endmodule

// File: tb/tb_ifmap_stream_loader.sv
// Self-checking bench for ifmap_stream_loader (H=W=4, DW=8); framing tests need IFMAP_TLAST_CHECK_EN.
module tb_ifmap_stream_loader;

  localparam int H = 4;
  localparam int W = 4;
  localparam int N = H * W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic [7:0]  ifmap_out [0:H-1][0:W-1];
  logic        acc_en;
  logic        acc_done = 1'b0;
  logic [15:0] frame_cnt;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [7:0] exp_buf [0:H-1][0:W-1];
  bit err_seen = 0;

  ifmap_stream_loader #(
    .IFMAP_HEIGHT (H),
    .IFMAP_WIDTH  (W),
    .DATA_WIDTH   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .ifmap_out (ifmap_out),
    .acc_en    (acc_en),
    .acc_done  (acc_done),
    .frame_cnt (frame_cnt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && frame_err) err_seen = 1;

  // Presents one beat (optionally with random idle cycles); returns just after the accepting edge
  task automatic push_beat(input logic [7:0] d, input logic l, input bit gaps);
    bit done = 0;
    int t = 0;
    while (!done) begin
      @(negedge clk);
      if (gaps && $urandom_range(1, 0) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        done    = s_ready;
      end
      t++;
      if (!done && t > 200) begin
        checks++; errors++;
        $display("FAIL push_timeout: s_ready=%0b never accepted beat, required 1", s_ready);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_buffer(input string name);
    int bad = 0;
    checks++;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (ifmap_out[r][c] !== exp_buf[r][c]) begin
          if (bad == 0)
            $display("FAIL %s: buf[%0d][%0d]=%0h required %0h", name, r, c, ifmap_out[r][c], exp_buf[r][c]);
          bad++;
        end
    if (bad != 0) errors++;
  endtask

  // Full frame: model records pixels, expects acc_en only after the final beat and frame_cnt+1
  task automatic send_frame(input bit gaps, input bit ramp, input string name);
    logic [7:0] pix [0:N-1];
    bit early = 0;
    for (int i = 0; i < N; i++) pix[i] = ramp ? 8'(i) : 8'($urandom_range(255, 0));
    for (int i = 0; i < N; i++) begin
      push_beat(pix[i], (i == N - 1), gaps);
      if (i != N - 1 && acc_en !== 1'b0) early = 1;
    end
    for (int i = 0; i < N; i++) exp_buf[i / W][i % W] = pix[i];
    exp_cnt = (exp_cnt + 1) % 65536;
    checks++;
    if (early || acc_en !== 1'b1) begin
      errors++;
      $display("FAIL %s_acc_en: early=%0b acc_en=%0b after last beat, required early=0 acc_en=1", name, early, acc_en);
    end
    checks++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_frame_cnt: got %0d required %0d", name, frame_cnt, exp_cnt);
    end
    check_buffer(name);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic release_pulse(input string name);
    @(negedge clk);
    s_valid  = 1'b0;
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    checks++;
    if (acc_en !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: acc_en=%0b s_ready=%0b required 0 0", name, acc_en, s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_reload: s_ready=%0b required 1", name, s_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; acc_done = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || acc_en !== 1'b0 || frame_cnt !== 16'd0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: s_ready=%0b acc_en=%0b frame_cnt=%0d frame_err=%0b required 0 0 0 0",
               s_ready, acc_en, frame_cnt, frame_err);
    end
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: s_ready=%0b required 1", s_ready);
    end
  endtask

  task automatic test_ramp_frame();
    send_frame(0, 1, "ramp");
  endtask

  task automatic test_run_stall();
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || acc_en !== 1'b1) begin
        errors++;
        $display("FAIL run_stall: s_ready=%0b acc_en=%0b required 0 1", s_ready, acc_en);
      end
    end
    s_valid = 1'b0;
    check_buffer("run_frozen");
    release_pulse("run");
  endtask

  task automatic test_done_level();
    send_frame(0, 0, "level_frame");
    @(negedge clk);
    acc_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || acc_en !== 1'b0) begin
        errors++;
        $display("FAIL done_level_hold: cycle %0d s_ready=%0b acc_en=%0b required 0 0", k, s_ready, acc_en);
      end
    end
    acc_done = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || frame_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL done_level_reload: s_ready=%0b frame_cnt=%0d required 1 %0d", s_ready, frame_cnt, exp_cnt);
    end
    send_frame(0, 0, "level_next");
    release_pulse("level_next");
  endtask

  task automatic test_gaps();
    test_reset();
    for (int f = 0; f < 3; f++) begin
      send_frame(1, 0, "gaps");
      release_pulse("gaps");
    end
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL gaps_total: frame_cnt=%0d required 3", frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    for (int i = 0; i < 8; i++) push_beat(8'(8'hF0 + i), 1'b0, 0);
    test_reset();
    send_frame(0, 0, "after_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (acc_en !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_in_run: acc_en=%0b frame_cnt=%0d required 0 0", acc_en, frame_cnt);
    end
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
  endtask

`ifdef IFMAP_TLAST_CHECK_EN
  task automatic test_tlast();
    test_reset();
    for (int i = 0; i < 6; i++) push_beat(8'(i), (i == 5), 0);
    checks++;
    if (frame_err !== 1'b1 || acc_en !== 1'b0) begin
      errors++;
      $display("FAIL early_last: frame_err=%0b acc_en=%0b required 1 0", frame_err, acc_en);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width: frame_err=%0b required 0", frame_err);
    end
    for (int i = 0; i < N; i++) push_beat(8'($urandom_range(255, 0)), 1'b0, 0);
    checks++;
    if (frame_err !== 1'b1 || acc_en !== 1'b0) begin
      errors++;
      $display("FAIL missing_last: frame_err=%0b acc_en=%0b required 1 0", frame_err, acc_en);
    end
    for (int i = 0; i < 3; i++) push_beat(8'h55, (i == 2), 1);
    checks++;
    if (frame_err !== 1'b0 || acc_en !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL skip: frame_err=%0b acc_en=%0b s_ready=%0b required 0 0 1", frame_err, acc_en, s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    send_frame(0, 0, "clean_after_skip");
    release_pulse("clean_after_skip");
  endtask
`else
  task automatic test_no_frame_err();
    checks++;
    if (err_seen !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_tied: seen=%0b required 0", err_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_frame();
    test_run_stall();
    test_done_level();
    test_gaps();
    test_reset_mid();
`ifdef IFMAP_TLAST_CHECK_EN
    test_tlast();
`else
    test_no_frame_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
